// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int unsigned DIV_W = 16;

    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFS = 2'd2;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    // A zero divisor would stall the bit counter, so it is promoted to 1.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers wrap naturally, count is one bit wider.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and serializer FSM.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH  = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  memWrite,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        txIrq
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       ofs;
    logic             push_req;
    logic             ovf_clr;
    logic             div_wr;
    logic [DIV_W-1:0] div_merged;
    logic [DIV_W-1:0] div;
    logic             ovf;
    logic [7:0]       status;

    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    state_t           state, state_next;
    logic [7:0]       sh, sh_next;
    logic [DIV_W-1:0] bit_div, bit_div_next;
    logic [DIV_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       idx, idx_next, idx_inc;
    logic             tx_next;
    logic             load;

    logic             unused_bits;
    assign unused_bits = ^{addr[10:2], memWrite[3:2], wdata[31:16]};

    // Register decode
    assign ofs        = addr[1:0];
    assign push_req   = en && memWrite[0] && (ofs == TXDATA_OFS);
    assign ovf_clr    = en && memWrite[0] && (ofs == STATUS_OFS) && wdata[ST_OVF];
    assign div_wr     = en && (ofs == BAUDDIV_OFS) && (|memWrite[1:0]);
    assign div_merged = {memWrite[1] ? wdata[15:8] : div[15:8],
                         memWrite[0] ? wdata[7:0]  : div[7:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= DEFAULT_DIV;
            ovf <= 1'b0;
        end else begin
            if (div_wr) div <= clamp_div(div_merged);
            if (push_req && fifo_full) ovf <= 1'b1;
            else if (ovf_clr)          ovf <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_OVF]   = ovf;
        status[7:4]      = 4'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        if (en) begin
            case (ofs)
                STATUS_OFS:  rdata = {24'h0, status};
                BAUDDIV_OFS: rdata = {16'h0, div};
                default:     rdata = '0;
            endcase
        end
    end

    assign txIrq = fifo_empty && (state == IDLE);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            sh       <= '0;
            bit_div  <= '0;
            baud_cnt <= '0;
            idx      <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            sh       <= sh_next;
            bit_div  <= bit_div_next;
            baud_cnt <= baud_cnt_next;
            idx      <= idx_next;
            tx       <= tx_next;
        end
    end

    // Serializer; 'load' starts a frame from IDLE or straight out of STOP.
    always_comb begin
        state_next    = state;
        sh_next       = sh;
        bit_div_next  = bit_div;
        baud_cnt_next = baud_cnt;
        idx_next      = idx;
        tx_next       = tx;
        fifo_pop      = 1'b0;
        load          = 1'b0;
        idx_inc       = idx + 3'd1;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                load    = !fifo_empty;
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_next    = DATA;
                    idx_next      = '0;
                    tx_next       = sh[0];
                    baud_cnt_next = bit_div - DIV_W'(1);
                end else begin
                    baud_cnt_next = baud_cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_next = bit_div - DIV_W'(1);
                    if (idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next = idx_inc;
                        tx_next  = sh[idx_inc];
                    end
                end else begin
                    baud_cnt_next = baud_cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    if (fifo_empty) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - DIV_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            fifo_pop      = 1'b1;
            sh_next       = fifo_dout;
            bit_div_next  = div;
            baud_cnt_next = div - DIV_W'(1);
            state_next    = START;
            tx_next       = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio against a queue-based line/FIFO model.
module tb_uart_tx_mmio;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_BAUDDIV = 2'd2;
    localparam logic [1:0] A_RSVD    = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  memWrite;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        txIrq;

    int n_asserts = 0;
    int n_fail    = 0;

    logic cap[$];
    logic expq[$];

    always #5 clk = ~clk;

    uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .memWrite (memWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx       (tx),
        .txIrq    (txIrq)
    );

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic e);
        en = e; memWrite = s; addr = {9'd0, a}; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; memWrite = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        en = 1'b1; memWrite = 4'd0; addr = {9'd0, a};
        #1 v = rdata;
        en = 1'b0;
    endtask

    task automatic capture(input int n);
        cap.delete();
        repeat (n) begin
            cap.push_back(tx);
            @(negedge clk);
        end
    endtask

    // Expected 8N1 line image: start, 8 data bits LSB first, stop; d clocks each.
    task automatic add_frame(input logic [7:0] b, input int d);
        repeat (d) expq.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (d) expq.push_back(b[i]);
        repeat (d) expq.push_back(1'b1);
    endtask

    task automatic add_idle(input int n);
        repeat (n) expq.push_back(1'b1);
    endtask

    function automatic logic [31:0] st_word(input int cnt, input bit ovf, input bit busy);
        logic [31:0] w;
        w = 32'(cnt) << 4;
        if (ovf)      w = w | 32'h8;
        if (busy)     w = w | 32'h4;
        if (cnt == 0) w = w | 32'h2;
        if (cnt == 8) w = w | 32'h1;
        return w;
    endfunction

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0; en = 1'b0; memWrite = 4'd0; addr = 11'd1; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_asserts++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b want=1", tx); end
        n_asserts++; if (txIrq !== 1'b1) begin n_fail++; $display("FAIL reset_irq got=%b want=1", txIrq); end
        n_asserts++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_en0 got=%h want=0", rdata); end
        reset = 1'b1;
        @(posedge clk); #1;
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL reset_status got=%h want=2", v); end
        bus_read(A_BAUDDIV, v);
        n_asserts++; if (v !== 32'h1B2) begin n_fail++; $display("FAIL reset_div got=%h want=1b2", v); end
        bus_read(A_TXDATA, v);
        n_asserts++; if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read got=%h want=0", v); end
        bus_read(A_RSVD, v);
        n_asserts++; if (v !== 32'h0) begin n_fail++; $display("FAIL rsvd_read got=%h want=0", v); end
    endtask

    task automatic test_single;
        logic [31:0] v;
        logic [7:0]  b;
        int          d, first;
        for (int f = 0; f < 4; f++) begin
            b = (f == 0) ? 8'h55 : 8'($urandom);
            d = (f == 0) ? 4 : int'($urandom_range(1, 5));
            @(negedge clk);
            bus_write(A_BAUDDIV, 32'(d), 4'b0011, 1'b1);
            @(negedge clk);
            expq.delete();
            add_idle(2); add_frame(b, d); add_idle(3);
            fork
                begin
                    bus_write(A_TXDATA, {24'($urandom), b}, 4'b0001, 1'b1);
                    bus_read(A_STATUS, v);
                    n_asserts++; if (v !== 32'h10) begin n_fail++; $display("FAIL single_queued got=%h want=10", v); end
                    n_asserts++; if (txIrq !== 1'b0) begin n_fail++; $display("FAIL single_irq got=%b want=0", txIrq); end
                    @(posedge clk); #1;
                    bus_read(A_STATUS, v);
                    n_asserts++; if (v !== 32'h6) begin n_fail++; $display("FAIL single_popped got=%h want=6", v); end
                end
                capture(expq.size());
            join
            first = -1;
            foreach (expq[i]) if (first < 0 && cap[i] !== expq[i]) first = i;
            n_asserts++;
            if (first >= 0) begin
                n_fail++;
                $display("FAIL single_stream byte=%h div=%0d idx=%0d got=%b want=%b", b, d, first, cap[first], expq[first]);
            end
            bus_read(A_STATUS, v);
            n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL single_done got=%h want=2", v); end
            n_asserts++; if (txIrq !== 1'b1) begin n_fail++; $display("FAIL single_irq_done got=%b want=1", txIrq); end
        end
    endtask

    task automatic test_burst;
        logic [31:0] v, st_exp;
        logic [7:0]  bytes[10];
        logic [7:0]  q[$];
        logic [7:0]  sent[$];
        bit          ovf_m, full_m;
        int          free_at, first;
        @(negedge clk);
        bus_write(A_BAUDDIV, 32'd2, 4'b0011, 1'b1);
        foreach (bytes[k]) bytes[k] = 8'($urandom);
        // One write per edge; the line takes a byte whenever it is free.
        ovf_m = 1'b0; free_at = 0;
        for (int e = 0; e < 10; e++) begin
            full_m = (q.size() == 8);
            if (q.size() > 0 && e >= free_at) begin
                sent.push_back(q.pop_front());
                free_at = e + 20;
            end
            if (full_m) ovf_m = 1'b1;
            else        q.push_back(bytes[e]);
        end
        st_exp = st_word(q.size(), ovf_m, 1'b1);
        while (q.size() > 0) sent.push_back(q.pop_front());
        expq.delete();
        add_idle(2);
        foreach (sent[k]) add_frame(sent[k], 2);
        add_idle(4);
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 10; k++) bus_write(A_TXDATA, 32'(bytes[k]), 4'b0001, 1'b1);
                bus_read(A_STATUS, v);
                n_asserts++; if (v !== st_exp) begin n_fail++; $display("FAIL burst_status got=%h want=%h", v, st_exp); end
            end
            capture(expq.size());
        join
        first = -1;
        foreach (expq[i]) if (first < 0 && cap[i] !== expq[i]) first = i;
        n_asserts++;
        if (first >= 0) begin
            n_fail++;
            $display("FAIL burst_stream idx=%0d got=%b want=%b", first, cap[first], expq[first]);
        end
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== st_word(0, ovf_m, 1'b0)) begin n_fail++; $display("FAIL burst_ovf got=%h want=%h", v, st_word(0, ovf_m, 1'b0)); end
        bus_write(A_STATUS, 32'h8, 4'b0010, 1'b1);
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== st_word(0, ovf_m, 1'b0)) begin n_fail++; $display("FAIL ovf_lane1 got=%h want=%h", v, st_word(0, ovf_m, 1'b0)); end
        bus_write(A_STATUS, 32'h8, 4'b0001, 1'b1);
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL ovf_clear got=%h want=2", v); end
    endtask

    task automatic test_div;
        logic [31:0] v, d;
        logic [15:0] mdiv;
        logic [3:0]  s;
        int          first;
        @(negedge clk);
        bus_write(A_BAUDDIV, 32'd0, 4'b0011, 1'b1);
        mdiv = 16'd1;
        bus_read(A_BAUDDIV, v);
        n_asserts++; if (v !== 32'h1) begin n_fail++; $display("FAIL div_zero got=%h want=1", v); end
        for (int k = 0; k < 6; k++) begin
            s = 4'($urandom);
            d = $urandom;
            if (s[0]) mdiv[7:0]  = d[7:0];
            if (s[1]) mdiv[15:8] = d[15:8];
            if (mdiv == 16'd0) mdiv = 16'd1;
            bus_write(A_BAUDDIV, d, s, 1'b1);
            bus_read(A_BAUDDIV, v);
            n_asserts++; if (v !== {16'h0, mdiv}) begin n_fail++; $display("FAIL div_lanes strobe=%b got=%h want=%h", s, v, {16'h0, mdiv}); end
        end
        bus_write(A_BAUDDIV, 32'hFFFF_0000, 4'b0011, 1'b1);
        @(negedge clk);
        expq.delete();
        add_idle(2); add_frame(8'hA5, 1); add_idle(2);
        fork
            bus_write(A_TXDATA, 32'hA5, 4'b0001, 1'b1);
            capture(expq.size());
        join
        first = -1;
        foreach (expq[i]) if (first < 0 && cap[i] !== expq[i]) first = i;
        n_asserts++;
        if (first >= 0) begin
            n_fail++;
            $display("FAIL div1_stream idx=%0d got=%b want=%b", first, cap[first], expq[first]);
        end
    endtask

    task automatic test_div_change;
        logic [31:0] v;
        logic [7:0]  a, b;
        int          first;
        a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
        bus_write(A_BAUDDIV, 32'd4, 4'b0011, 1'b1);
        @(negedge clk);
        expq.delete();
        add_idle(2); add_frame(a, 4); add_frame(b, 8); add_idle(3);
        fork
            begin
                bus_write(A_TXDATA, 32'(a), 4'b0001, 1'b1);
                bus_write(A_TXDATA, 32'(b), 4'b0001, 1'b1);
                bus_write(A_BAUDDIV, 32'd8, 4'b0011, 1'b1);
                bus_read(A_BAUDDIV, v);
                n_asserts++; if (v !== 32'h8) begin n_fail++; $display("FAIL div_mid got=%h want=8", v); end
            end
            capture(expq.size());
        join
        first = -1;
        foreach (expq[i]) if (first < 0 && cap[i] !== expq[i]) first = i;
        n_asserts++;
        if (first >= 0) begin
            n_fail++;
            $display("FAIL divchg_stream idx=%0d got=%b want=%b", first, cap[first], expq[first]);
        end
    endtask

    task automatic test_ignored;
        logic [31:0] v;
        @(negedge clk);
        bus_write(A_TXDATA,  $urandom, 4'b0001, 1'b0);
        bus_write(A_TXDATA,  $urandom, 4'b0000, 1'b1);
        bus_write(A_TXDATA,  $urandom, 4'b1110, 1'b1);
        bus_write(A_RSVD,    $urandom, 4'b1111, 1'b1);
        bus_write(A_BAUDDIV, 32'h1234, 4'b0011, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL ignored_status got=%h want=2", v); end
        n_asserts++; if (tx !== 1'b1) begin n_fail++; $display("FAIL ignored_tx got=%b want=1", tx); end
        bus_read(A_BAUDDIV, v);
        n_asserts++; if (v !== 32'h8) begin n_fail++; $display("FAIL ignored_div got=%h want=8", v); end
        bus_read(A_RSVD, v);
        n_asserts++; if (v !== 32'h0) begin n_fail++; $display("FAIL ignored_rsvd got=%h want=0", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int          first;
        @(negedge clk);
        bus_write(A_BAUDDIV, 32'd4, 4'b0011, 1'b1);
        for (int k = 0; k < 4; k++) bus_write(A_TXDATA, $urandom, 4'b0001, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== st_word(3, 1'b0, 1'b1)) begin n_fail++; $display("FAIL pre_reset got=%h want=%h", v, st_word(3, 1'b0, 1'b1)); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_asserts++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset_tx got=%b want=1", tx); end
        n_asserts++; if (txIrq !== 1'b1) begin n_fail++; $display("FAIL midreset_irq got=%b want=1", txIrq); end
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL midreset_status got=%h want=2", v); end
        bus_read(A_BAUDDIV, v);
        n_asserts++; if (v !== 32'h1B2) begin n_fail++; $display("FAIL midreset_div got=%h want=1b2", v); end
        reset = 1'b1;
        @(negedge clk);
        expq.delete();
        add_idle(60);
        capture(expq.size());
        first = -1;
        foreach (expq[i]) if (first < 0 && cap[i] !== expq[i]) first = i;
        n_asserts++;
        if (first >= 0) begin
            n_fail++;
            $display("FAIL after_reset_line idx=%0d got=%b want=%b", first, cap[first], expq[first]);
        end
        bus_read(A_STATUS, v);
        n_asserts++; if (v !== 32'h2) begin n_fail++; $display("FAIL after_reset_status got=%h want=2", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_div();
        test_div_change();
        test_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
